loop_index_unit: RTL and testbench

LOOP_INDEX_UNIT -- requirements
Module: loop_index_unit

---
 rtl/loop_index_unit.sv | 117 +++++++++++
 tb/tb_loop_index_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/loop_index_unit.sv
// Nested loop index generator: LEVELS counters with per-level limits, level 0 innermost.
// Optional abort input is enabled by defining LOOP_INDEX_UNIT_ABORT_EN.
module loop_index_unit #(
    parameter int WIDTH  = 8,
    parameter int LEVELS = 3,
    parameter int SELW   = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [WIDTH-1:0]  BusOut,
    input  logic [LEVELS-1:0] lim_wen,
    input  logic              start,
    input  logic              step,
    input  logic [SELW-1:0]   sel,
    output logic [WIDTH-1:0]  idx_out,
    output logic              z,
    output logic [LEVELS-1:0] wrap,
    output logic              busy,
    output logic              done
`ifdef LOOP_INDEX_UNIT_ABORT_EN
    ,
    input  logic              abort
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                         state_q, state_d;
    logic [LEVELS-1:0][WIDTH-1:0]   idx_q, idx_d;
    logic [LEVELS-1:0][WIDTH-1:0]   lim_q, lim_d;
    logic [LEVELS-1:0]              wrap_q, wrap_d;
    logic                           carry_top;
    logic                           any_zero;
    logic                           abort_w;

`ifdef LOOP_INDEX_UNIT_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < LEVELS; i++) begin
            if (lim_q[i] == '0) any_zero = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            lim_q   <= '0;
            wrap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lim_q   <= lim_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = any_zero ? S_DONE : S_RUN;
            S_RUN: begin
                if (abort_w)        state_d = S_IDLE;
                else if (carry_top) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Ripple carry: a level advances only when every inner level sits at its last value.
    always_comb begin
        logic c;
        logic last;
        idx_d  = idx_q;
        lim_d  = lim_q;
        wrap_d = '0;
        c      = (state_q == S_RUN) && step && !abort_w;
        for (int i = 0; i < LEVELS; i++) begin
            last = (idx_q[i] == lim_q[i] - WIDTH'(1));
            if (c) begin
                idx_d[i]  = last ? '0 : idx_q[i] + WIDTH'(1);
                wrap_d[i] = last;
            end
            c = c && last;
        end
        carry_top = c;
        if ((state_q == S_IDLE && start) || (state_q == S_RUN && abort_w) || carry_top)
            idx_d = '0;
        // Limits are frozen while a nest is running; start sees the pre-write values.
        if (state_q != S_RUN) begin
            for (int i = 0; i < LEVELS; i++) begin
                if (lim_wen[i]) lim_d[i] = BusOut;
            end
        end
    end

    always_comb begin
        busy    = (state_q == S_RUN);
        done    = (state_q == S_DONE);
        wrap    = wrap_q;
        idx_out = '0;
        z       = 1'b0;
        for (int i = 0; i < LEVELS; i++) begin
            if (sel == SELW'(i)) begin
                idx_out = idx_q[i];
                z       = (idx_q[i] == lim_q[i] - WIDTH'(1));
            end
        end
    end

endmodule

// File: tb/tb_loop_index_unit.sv
// Directed self-checking bench for loop_index_unit (default parameters).
module tb_loop_index_unit;

    logic       Clk;
    logic       Rst;
    logic [7:0] BusOut;
    logic [2:0] lim_wen;
    logic       start;
    logic       step;
    logic [1:0] sel;
    logic [7:0] idx_out;
    logic       z;
    logic [2:0] wrap;
    logic       busy;
    logic       done;
`ifdef LOOP_INDEX_UNIT_ABORT_EN
    logic       abort;
`endif

    int checks;
    int failures;

    loop_index_unit #(.WIDTH(8), .LEVELS(3), .SELW(2)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .BusOut  (BusOut),
        .lim_wen (lim_wen),
        .start   (start),
        .step    (step),
        .sel     (sel),
        .idx_out (idx_out),
        .z       (z),
        .wrap    (wrap),
        .busy    (busy),
        .done    (done)
`ifdef LOOP_INDEX_UNIT_ABORT_EN
        ,
        .abort   (abort)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic set_lims(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
        BusOut = l0; lim_wen = 3'b001; tick();
        BusOut = l1; lim_wen = 3'b010; tick();
        BusOut = l2; lim_wen = 3'b100; tick();
        lim_wen = 3'b000;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_steps(input int n);
        for (int k = 0; k < n; k++) begin
            step = 1'b1; tick(); step = 1'b0;
        end
    endtask

    task automatic idx_of(input logic [1:0] s, output logic [7:0] v, output logic zz);
        sel = s; #1; v = idx_out; zz = z;
    endtask

    task automatic run_until_done(output int n);
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            step = 1'b1; tick(); step = 1'b0;
            n++;
            if (done) break;
        end
    endtask

    initial begin
        logic [7:0] v;
        logic       zz;
        int         n, w0, w1, w2, early;

        checks = 0; failures = 0;
        Rst = 1'b1; BusOut = '0; lim_wen = '0; start = 0; step = 0; sel = 0;
`ifdef LOOP_INDEX_UNIT_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_idx", idx_out, 0);
        tick(); tick();
        Rst = 1'b0;
        tick();

        // step while idle is ignored
        do_steps(2);
        idx_of(2'd0, v, zz);
        chk("idle_step_idx", v, 0);
        chk("idle_step_busy", busy, 0);

        // first start after reset: limits are zero -> zero-trip
        do_start();
        chk("zt_reset_done", done, 1);
        chk("zt_reset_busy", busy, 0);
        tick();
        chk("zt_reset_done_pulse", done, 0);

        // limits (2,3,4), 24 steps
        set_lims(8'd2, 8'd3, 8'd4);
        do_start();
        chk("n234_busy", busy, 1);
        do_steps(5);
        idx_of(2'd0, v, zz); chk("n234_idx0", v, 1); chk("n234_z0", zz, 1);
        idx_of(2'd1, v, zz); chk("n234_idx1", v, 2); chk("n234_z1", zz, 1);
        idx_of(2'd2, v, zz); chk("n234_idx2", v, 0); chk("n234_z2", zz, 0);
        idx_of(2'd3, v, zz); chk("n234_sel3_idx", v, 0); chk("n234_sel3_z", zz, 0);
        sel = 2'd0;
        w0 = 0; w1 = 0; w2 = 0; early = 0;
        for (int k = 5; k < 24; k++) begin
            step = 1'b1; tick(); step = 1'b0;
            w0 += int'(wrap[0]); w1 += int'(wrap[1]); w2 += int'(wrap[2]);
            if (k < 23) early += int'(done);
        end
        // the first 5 steps produced two wraps on level 0
        chk("n234_wrap0", w0 + 2, 12);
        chk("n234_wrap1", w1, 4);
        chk("n234_wrap2", w2, 1);
        chk("n234_early_done", early, 0);
        chk("n234_done", done, 1);
        chk("n234_busy_end", busy, 0);
        chk("n234_wrap_last", wrap, 3'b111);
        tick();
        chk("n234_done_clear", done, 0);
        chk("n234_wrap_clear", wrap, 0);

        // limits (5,1,1)
        set_lims(8'd5, 8'd1, 8'd1);
        do_start();
        do_steps(4);
        idx_of(2'd0, v, zz); chk("n511_idx0", v, 4); chk("n511_z0", zz, 1);
        idx_of(2'd1, v, zz); chk("n511_idx1", v, 0); chk("n511_z1", zz, 1);
        sel = 2'd0;
        do_steps(1);
        chk("n511_wrap", wrap, 3'b111);
        chk("n511_done", done, 1);
        chk("n511_busy", busy, 0);
        tick();

        // limits (3,0,2): zero-trip
        set_lims(8'd3, 8'd0, 8'd2);
        do_start();
        chk("n302_done", done, 1);
        chk("n302_busy", busy, 0);
        tick();

        // write during RUN ignored
        set_lims(8'd4, 8'd4, 8'd4);
        do_start();
        BusOut = 8'd9; lim_wen = 3'b001; tick(); lim_wen = 3'b000;
        run_until_done(n);
        chk("n444_steps", n, 64);
        chk("n444_done", done, 1);
        tick();
        BusOut = 8'd9; lim_wen = 3'b001; tick(); lim_wen = 3'b000;
        do_start();
        run_until_done(n);
        chk("n944_steps", n, 144);
        tick();

        // start with coincident write uses pre-write limits
        BusOut = 8'd0; lim_wen = 3'b001; tick(); lim_wen = 3'b000;
        BusOut = 8'd2; lim_wen = 3'b001; start = 1'b1; tick();
        lim_wen = 3'b000; start = 1'b0;
        chk("coinc_zero_trip", done, 1);
        tick();
        do_start();
        chk("coinc_busy", busy, 1);
        run_until_done(n);
        chk("coinc_steps", n, 32);
        tick();

        // reset mid-run
        set_lims(8'd2, 8'd3, 8'd4);
        do_start();
        do_steps(10);
        Rst = 1'b1; #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_idx", idx_out, 0);
        chk("rstmid_done", done, 0);
        tick();
        Rst = 1'b0;
        early = 0;
        for (int k = 0; k < 4; k++) begin tick(); early += int'(done); end
        chk("rstmid_no_done", early, 0);
        do_start();
        chk("rstmid_lims_cleared", done, 1);
        tick();

`ifdef LOOP_INDEX_UNIT_ABORT_EN
        set_lims(8'd2, 8'd3, 8'd4);
        do_start();
        do_steps(9);
        step = 1'b1; abort = 1'b1; tick(); step = 1'b0; abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        idx_of(2'd0, v, zz); chk("abort_idx0", v, 0);
        idx_of(2'd1, v, zz); chk("abort_idx1", v, 0);
        sel = 2'd0;
        tick();
        chk("abort_no_done", done, 0);
`endif

        // limits (255,1,1)
        set_lims(8'd255, 8'd1, 8'd1);
        do_start();
        do_steps(254);
        idx_of(2'd0, v, zz); chk("n255_idx0", v, 254); chk("n255_z0", zz, 1);
        chk("n255_not_done", done, 0);
        do_steps(1);
        chk("n255_done", done, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
